// File: rtl/axil_wb_master_bridge.sv
// AXI-Lite slave to Wishbone classic master bridge.
// Each AXI-Lite write or read becomes exactly one Wishbone cycle, and only one
// transaction is in flight at a time. A stalled Wishbone slave is cut off
// after TIMEOUT strobe cycles, and the AXI side then gets SLVERR.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | nothing captured; accepts AW/W, or AR if no write is offered
// WR_COLLECT | one of AW/W captured, waiting for the other
// WB_WR      | Wishbone write cycle active (cyc/stb/we)
// WR_RESP    | bvalid held until bready
// WB_RD      | Wishbone read cycle active (cyc/stb)
// RD_RESP    | rvalid/rdata held until rready
module axil_wb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      axis_clk,
  input  logic                      axis_rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
  output logic [ADDR_WIDTH-1:0]     wbm_adr_o,
  output logic [DATA_WIDTH-1:0]     wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]     wbm_dat_i,
  input  logic                      wbm_ack_i
);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WB_WR, WR_RESP, WB_RD, RD_RESP
  } state_t;

  // Last count value before abort: STB is high for exactly TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t                    state, state_nxt;
  logic                      active;
  logic                      aw_got, w_got, aw_got_nxt, w_got_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic [15:0]               tmo_cnt;
  logic                      resp_err;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      in_collect, in_wb, tmo_hit;
  logic                      aw_hs, w_hs, ar_hs;

  // Readies stay low during reset and until the first edge after release.
  assign in_collect = active && (state == IDLE || state == WR_COLLECT);
  assign awready    = in_collect && !aw_got;
  assign wready     = in_collect && !w_got;
  assign arready    = active && (state == IDLE) && !awvalid && !wvalid;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign ar_hs      = arvalid && arready;
  assign in_wb      = (state == WB_WR) || (state == WB_RD);
  assign tmo_hit    = in_wb && !wbm_ack_i && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state decode plus Wishbone and AXI response outputs.
  always_comb begin
    state_nxt  = state;
    aw_got_nxt = aw_got | aw_hs;
    w_got_nxt  = w_got | w_hs;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = '0;
    wbm_adr_o  = '0;
    wbm_dat_o  = '0;
    bvalid     = 1'b0;
    bresp      = 2'b00;
    rvalid     = 1'b0;
    rresp      = 2'b00;
    rdata      = '0;
    case (state)
      IDLE, WR_COLLECT: begin
        if (aw_got_nxt && w_got_nxt) begin
          state_nxt  = WB_WR;
          aw_got_nxt = 1'b0;
          w_got_nxt  = 1'b0;
        end else if (aw_got_nxt || w_got_nxt) begin
          state_nxt = WR_COLLECT;
        end else if (ar_hs) begin
          state_nxt = WB_RD;
        end
      end
      WB_WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = wstrb_q;
        wbm_adr_o = addr_q;
        wbm_dat_o = wdata_q;
        if (wbm_ack_i || tmo_hit) state_nxt = WR_RESP;
      end
      WB_RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = '1;
        wbm_adr_o = addr_q;
        if (wbm_ack_i || tmo_hit) state_nxt = RD_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = {resp_err, 1'b0};
        if (bready) state_nxt = IDLE;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        rresp  = {resp_err, 1'b0};
        rdata  = rdata_q;
        if (rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture registers, timeout counter and response status.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      active   <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      tmo_cnt  <= '0;
      resp_err <= 1'b0;
      rdata_q  <= '0;
    end else begin
      active <= 1'b1;
      aw_got <= aw_got_nxt;
      w_got  <= w_got_nxt;
      if (aw_hs)      addr_q <= awaddr;
      else if (ar_hs) addr_q <= araddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      // Counter is zero whenever no cycle is active, so it starts clean.
      if (in_wb && !wbm_ack_i) tmo_cnt <= tmo_cnt + 16'd1;
      else                     tmo_cnt <= '0;
      if (in_wb) begin
        if (wbm_ack_i) begin
          resp_err <= 1'b0;
          if (state == WB_RD) rdata_q <= wbm_dat_i;
        end else if (tmo_hit) begin
          resp_err <= 1'b1;
          rdata_q  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_wb_master_bridge.sv
// Self-checking bench for axil_wb_master_bridge: table of transactions driven
// through one task, a Wishbone slave model and a response scoreboard, plus
// hand-written sequences for priority, stray ACK and mid-cycle reset.
module tb_axil_wb_master_bridge;

  localparam int TMO = 8;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  axil_wb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d;
    int          w_d;
    int          ack_d;
    int          hold_d;
  } vec_t;

  typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; } wb_exp_t;
  typedef struct { bit rd; logic [1:0] resp; logic [31:0] rdata; } rsp_exp_t;

  wb_exp_t  wb_q[$];
  rsp_exp_t resp_q[$];
  vec_t     vecs[8];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_no = 0;
  int          stb_cnt = 0;
  int          last_len = 0;
  int          ack_cyc = 0;
  int          sl_ack_d = 0;
  logic [31:0] sl_rdata = '0;
  bit          stray = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] all_outs();
    return {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
            wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
  endfunction

  initial forever begin
    @(posedge axis_clk);
    cyc_no++;
  end

  // Wishbone slave model: checks each request and ACKs after sl_ack_d strobe cycles.
  initial begin
    wb_exp_t e;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h5555_AAAA;
    forever begin
      @(negedge axis_clk);
      if (wbm_cyc_o && wbm_stb_o) begin
        if (stb_cnt == 0) begin
          if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
          else begin
            e = wb_q.pop_front();
            chk("wb_req", {wbm_we_o, wbm_adr_o, wbm_sel_o}, {e.we, e.adr, e.sel});
            if (e.we) chk("wb_wdat", wbm_dat_o, e.dat);
          end
        end
        wbm_ack_i = (sl_ack_d >= 0) && (stb_cnt == sl_ack_d);
        wbm_dat_i = wbm_ack_i ? sl_rdata : 32'h5555_AAAA;
        if (wbm_ack_i) ack_cyc = cyc_no;
        stb_cnt++;
      end else begin
        if (stb_cnt != 0) last_len = stb_cnt;
        stb_cnt   = 0;
        wbm_ack_i = stray;
        wbm_dat_i = 32'h5555_AAAA;
      end
    end
  end

  // Response scoreboard: compares every completed B/R handshake.
  initial begin
    rsp_exp_t r;
    forever begin
      @(negedge axis_clk);
      if ((bvalid && bready) || (rvalid && rready)) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          r = resp_q.pop_front();
          if (bvalid) chk("bresp", {1'b0, bresp}, {r.rd, r.resp});
          else        chk("rresp", {1'b1, rresp, rdata}, {r.rd, r.resp, r.rdata});
        end
      end
    end
  end

  // One transaction; starts and ends just after a rising edge.
  task automatic do_xfer(input vec_t v);
    bit          acked, aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs, early;
    bit          seen, done, stable;
    logic [1:0]  eresp;
    logic [31:0] erd;
    logic [33:0] first_val;
    int          elen, c, h, resp_at;
    acked = (v.ack_d >= 0) && (v.ack_d < TMO);
    eresp = acked ? 2'b00 : 2'b10;
    erd   = (v.rd && acked) ? v.data : 32'h0;
    elen  = acked ? v.ack_d + 1 : TMO;
    wb_q.push_back('{we: !v.rd, adr: v.addr, dat: v.data, sel: v.rd ? 4'hF : v.strb});
    resp_q.push_back('{rd: v.rd, resp: eresp, rdata: erd});
    sl_ack_d = v.ack_d;
    sl_rdata = v.data;
    aw_done = v.rd; w_done = v.rd; ar_done = !v.rd; early = 0; c = 0;
    awaddr = v.addr; araddr = v.addr; wdata = v.data; wstrb = v.strb;
    while (!(aw_done && w_done && ar_done) && c < 100) begin
      awvalid = !aw_done && (c >= v.aw_d);
      wvalid  = !w_done && (c >= v.w_d);
      arvalid = !ar_done;
      @(negedge axis_clk);
      if (wbm_cyc_o) early = 1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      @(posedge axis_clk); #1;
      aw_done |= aw_hs; w_done |= w_hs; ar_done |= ar_hs;
      c++;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("addr_phase", {aw_done, w_done, ar_done}, 3'b111);
    @(negedge axis_clk);
    chk("cyc_start", {wbm_cyc_o, early}, 2'b10);
    seen = 0; done = 0; stable = 1; h = 0; c = 0; resp_at = -1; first_val = '0;
    while (!done && c < 100) begin
      @(negedge axis_clk);
      if (v.rd ? rvalid : bvalid) begin
        if (!seen) begin
          seen = 1; resp_at = cyc_no;
          first_val = v.rd ? {rresp, rdata} : {bresp, 32'h0};
          if (wbm_cyc_o) stable = 0;
        end else if (first_val != (v.rd ? {rresp, rdata} : {bresp, 32'h0})) stable = 0;
        if (v.rd ? rready : bready) done = 1;
        else h++;
      end else if (seen) stable = 0;
      @(posedge axis_clk); #1;
      if (done) begin bready = 0; rready = 0; end
      else if (h > v.hold_d) begin bready = !v.rd; rready = v.rd; end
      c++;
    end
    chk("resp_done", done, 1);
    chk("resp_hold", stable, 1);
    chk("stb_len", last_len, elen);
    if (acked) chk("resp_latency", resp_at, ack_cyc + 1);
  endtask

  initial begin : main
    int   c, b_at, ar_at;
    bit   bad, hit;
    vec_t fresh;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int   c, b_at, ar_at;
    bit   bad, hit;
    vec_t fresh;
    vecs[0] = '{1'b0, 32'h3800_0010, 32'hA5A5_1234, 4'hF, 0, 0, 2, 0};
    vecs[1] = '{1'b0, 32'h3800_0020, 32'h1111_2222, 4'h3, 3, 0, 1, 1};
    vecs[2] = '{1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 4};
    vecs[3] = '{1'b0, 32'h3800_0030, 32'hCAFE_F00D, 4'h8, 0, 2, TMO - 1, 0};
    vecs[4] = '{1'b0, 32'h3800_0034, 32'h0BAD_CAFE, 4'h1, 1, 0, TMO, 0};
    vecs[5] = '{1'b1, 32'h3800_0008, 32'h1234_5678, 4'h0, 0, 0, -1, 2};
    vecs[6] = '{1'b1, 32'h3800_000C, 32'h8765_4321, 4'h0, 0, 0, TMO - 1, 0};
    vecs[7] = '{1'b0, 32'h3800_0040, 32'h0F0F_F0F0, 4'hC, 0, 0, -1, 2};

    axis_rst_n = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge axis_clk);
    chk("rst_state", all_outs(), '0);
    axis_rst_n = 1;
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    chk("idle_rdy", {awready, wready, arready}, 3'b111);
    @(posedge axis_clk); #1;

    for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

    // Write and read offered together: write goes first, read waits for B.
    sl_ack_d = 1; sl_rdata = 32'h7777_0001;
    wb_q.push_back('{we: 1'b1, adr: 32'h3800_0050, dat: 32'h0000_BEEF, sel: 4'hF});
    wb_q.push_back('{we: 1'b0, adr: 32'h3800_0054, dat: 32'h0, sel: 4'hF});
    resp_q.push_back('{rd: 1'b0, resp: 2'b00, rdata: 32'h0});
    resp_q.push_back('{rd: 1'b1, resp: 2'b00, rdata: 32'h7777_0001});
    awaddr = 32'h3800_0050; wdata = 32'h0000_BEEF; wstrb = 4'hF; araddr = 32'h3800_0054;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge axis_clk);
    chk("prio_rdy", {awready, wready, arready}, 3'b110);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
    b_at = -1; ar_at = -1; bad = 0; c = 0;
    while (ar_at < 0 && c < 60) begin
      @(negedge axis_clk);
      if (bvalid && bready && b_at < 0) b_at = c;
      if (arready && b_at < 0) bad = 1;
      if (arready && arvalid) ar_at = c;
      @(posedge axis_clk); #1;
      if (ar_at >= 0) arvalid = 0;
      c++;
    end
    chk("prio_order", {bad, b_at >= 0, ar_at > b_at}, 3'b011);
    c = 0;
    while (resp_q.size() != 0 && c < 60) begin
      @(posedge axis_clk); #1;
      c++;
    end
    chk("prio_drain", resp_q.size(), 0);
    bready = 0; rready = 0; arvalid = 0;
    @(posedge axis_clk); #1;

    // ACK with no cycle open must not produce anything.
    stray = 1; bad = 0;
    repeat (3) begin
      @(negedge axis_clk);
      if (wbm_cyc_o || bvalid || rvalid) bad = 1;
    end
    stray = 0;
    repeat (2) begin
      @(negedge axis_clk);
      if (wbm_cyc_o || bvalid || rvalid) bad = 1;
    end
    chk("stray_ack", bad, 0);
    @(posedge axis_clk); #1;
    do_xfer(vecs[2]);

    // Reset while STB is high: outputs clear at once, no response follows.
    sl_ack_d = -1;
    wb_q.push_back('{we: 1'b1, adr: 32'h3800_0060, dat: 32'h1357_9BDF, sel: 4'hF});
    awaddr = 32'h3800_0060; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(negedge axis_clk);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
    hit = 0; c = 0;
    while (!hit && c < 20) begin
      @(negedge axis_clk);
      hit = wbm_stb_o;
      c++;
    end
    chk("rst_mid_stb", hit, 1);
    #2 axis_rst_n = 0;
    #1 chk("rst_mid_clear", all_outs(), '0);
    repeat (2) @(negedge axis_clk);
    chk("rst_mid_hold", all_outs(), '0);
    axis_rst_n = 1;
    @(posedge axis_clk); #1;
    fresh = '{1'b0, 32'h3800_0070, 32'h2468_ACE0, 4'hF, 0, 0, 1, 0};
    do_xfer(fresh);

    chk("sb_empty", {wb_q.size() == 0, resp_q.size() == 0}, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_wb_master_bridge.md
Name: axil_wb_master_bridge

Overview:
- AXI-Lite slave front end that turns each AXI-Lite write or read into one Wishbone classic master cycle.
- Used where an AXI-Lite initiator (test harness or accelerator control path) must reach Wishbone-side registers and memory in the user project area.
- It is the reverse of the Wishbone-to-AXI path in the user project wrapper: here AXI is the requester and Wishbone is the responder.
- One outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, width of AXI address and Wishbone address.
- DATA_WIDTH, 32, data width; fixed at 32 in this revision, SEL is DATA_WIDTH/8.
- TIMEOUT, 255, number of cycles STB may stay high without ACK before the cycle is aborted (1..65535).

Ports:
- axis_clk  in  1  sole clock
- axis_rst_n  in  1  reset, asynchronous, active-low
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  ADDR_WIDTH  write address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data
- wstrb  in  4  write byte strobes
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response: 00 OKAY, 10 SLVERR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  ADDR_WIDTH  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 10 SLVERR
- wbm_cyc_o  out  1  Wishbone CYC
- wbm_stb_o  out  1  Wishbone STB
- wbm_we_o  out  1  Wishbone WE
- wbm_sel_o  out  4  Wishbone SEL
- wbm_adr_o  out  ADDR_WIDTH  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone ACK

Behaviour:
- Clocking and reset: single clock axis_clk; reset axis_rst_n is asynchronous, active-low.
- Reset values: every output 0, including all ready/valid flags, bresp, rresp, rdata and all wbm_* outputs. FSM returns to IDLE; capture flags and timeout counter cleared.
- FSM states: IDLE, WR_COLLECT, WB_WR, WR_RESP, WB_RD, RD_RESP.
- awready = 1 in IDLE or WR_COLLECT while AW is not yet captured; otherwise 0.
- wready = 1 in IDLE or WR_COLLECT while W is not yet captured; otherwise 0.
- arready = 1 only in IDLE when awvalid=0 and wvalid=0. Writes have priority on simultaneous requests.
- AW and W are accepted independently, in either order or in the same cycle. awaddr, wdata and wstrb are registered on their handshake.
- IDLE -> WR_COLLECT when only one of AW/W is captured.
- IDLE or WR_COLLECT -> WB_WR in the cycle after both AW and W are captured.
- In WB_WR: cyc=stb=we=1, sel=captured wstrb, adr and dat_o from the captured values.
- IDLE -> WB_RD in the cycle after the AR handshake. In WB_RD: cyc=stb=1, we=0, sel=4'hF.
- On wbm_ack_i=1 in WB_WR or WB_RD:
  - cyc and stb drop at the next edge.
  - FSM moves to WR_RESP with bvalid=1, bresp=00, or to RD_RESP with rvalid=1, rresp=00, rdata=wbm_dat_i sampled at the ACK edge.
- Latency: last of AW/W handshake at edge N -> cyc high from N+1. ACK at edge M -> bvalid/rvalid high from M+1.
- Timeout:
  - Counter clears on entry to WB_WR/WB_RD and increments each cycle STB is high without ACK.
  - When it reaches TIMEOUT, the cycle is aborted: cyc/stb drop, response is SLVERR (10), and rdata=0 for reads.
  - ACK in the same cycle as the terminal count wins and gives OKAY.
- Response hold: bvalid/rvalid stay high and bresp/rresp/rdata stay stable until bready/rready. After the handshake, FSM -> IDLE, bvalid/rvalid drop at the next edge, and the next transaction may start at the following edge.
- Stray ACK: wbm_ack_i while cyc=0 is ignored.
- Ready masking: no AXI ready is asserted while a Wishbone cycle or a response is pending.
- Reset mid-transaction: outputs are cleared immediately, with no response issued. The cycle in flight is dropped.

Test Plan:
- Write, AW and W in the same cycle: awaddr=0x3800_0010, wdata=0xA5A5_1234, wstrb=0xF; slave ACKs 2 cycles after stb -> wbm_adr_o=0x3800_0010, wbm_dat_o=0xA5A5_1234, sel=F, we=1; bvalid 1 cycle after ACK, bresp=00.
- W three cycles before AW, wstrb=0x3 -> no cyc until the AW handshake; cyc rises the cycle after it; sel=0x3.
- Read of 0x3800_0004; slave returns 0xDEAD_BEEF with ACK; rready held low 4 cycles -> rvalid and rdata=0xDEAD_BEEF held stable until the rready handshake; rresp=00.
- Simultaneous awvalid, wvalid and arvalid in IDLE -> write completes first, arready=0 throughout; the read is accepted after bvalid/bready.
- TIMEOUT=8, slave never ACKs on a read -> stb high exactly 8 cycles, then rvalid with rresp=10 and rdata=0; cyc=0.
- axis_rst_n pulled low while stb=1 -> all outputs 0 asynchronously; after release, a fresh write completes normally with bresp=00.
